// File: rtl/i2c_subordinate.sv
// I2C target with a 7-bit address. Every written byte is ACKed;
// reads return tx_data byte after byte until the master NACKs.
module i2c_subordinate #(
    parameter logic [6:0] ADDR = 7'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       addr_match,
    output logic       busy,
    output logic [2:0] state_out
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX        = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX        = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_t;

    state_t     state_q, state_d;
    // [0],[1] are the synchronizer, [2] is the edge-history copy
    logic [2:0] scl_q, sda_q;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] txsh_q, txsh_d;
    logic       rw_q, rw_d;
    logic       ack_q, ack_d;
    logic       sda_oe_d;
    logic [7:0] rx_data_d;
    logic       rx_valid_d, tx_req_d;
    logic       match_d, busy_d;
    logic       scl_rise, scl_fall;
    logic       start_c, stop_c;

    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign start_c   = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop_c    = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    assign state_out = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q      <= 3'b111;
            sda_q      <= 3'b111;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            txsh_q     <= '0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b1;
            sda_oe     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            tx_req     <= 1'b0;
            addr_match <= 1'b0;
            busy       <= 1'b0;
        end else begin
            scl_q      <= {scl_q[1:0], scl};
            sda_q      <= {sda_q[1:0], sda_in};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            txsh_q     <= txsh_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            sda_oe     <= sda_oe_d;
            rx_data    <= rx_data_d;
            rx_valid   <= rx_valid_d;
            tx_req     <= tx_req_d;
            addr_match <= match_d;
            busy       <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        txsh_d     = txsh_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        sda_oe_d   = sda_oe;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        match_d    = addr_match;
        busy_d     = busy;
        if (start_c) begin
            state_d  = ST_ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b1;
            match_d  = 1'b0;
        end else if (stop_c) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            match_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: sda_oe_d = 1'b0;
                ST_ADDR: begin
                    if (scl_rise && !cnt_q[3]) begin
                        shreg_d = {shreg_q[6:0], sda_q[1]};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q[3]) begin
                        cnt_d = '0;
                        rw_d  = shreg_q[0];
                        if (shreg_q[7:1] == ADDR) begin
                            state_d  = ST_ADDR_ACK;
                            sda_oe_d = 1'b1;
                            match_d  = 1'b1;
                        end else begin
                            state_d  = ST_WAIT_STOP;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = '0;
                        if (rw_q) begin
                            state_d  = ST_TX;
                            txsh_d   = tx_data;
                            tx_req_d = 1'b1;
                            sda_oe_d = ~tx_data[7];
                        end else begin
                            state_d  = ST_RX;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_RX: begin
                    if (scl_rise && !cnt_q[3]) begin
                        shreg_d = {shreg_q[6:0], sda_q[1]};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q[3]) begin
                        cnt_d      = '0;
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                        sda_oe_d   = 1'b1;
                        state_d    = ST_RX_ACK;
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_RX;
                    end
                end
                ST_TX: begin
                    if (scl_rise && !cnt_q[3]) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q[3]) begin
                        cnt_d    = '0;
                        sda_oe_d = 1'b0;
                        state_d  = ST_TX_ACK;
                    end else if (scl_fall) begin
                        // txsh_q[7] is already on the bus; present the next bit
                        txsh_d   = {txsh_q[6:0], 1'b0};
                        sda_oe_d = ~txsh_q[6];
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise) begin
                        ack_d = sda_q[1];
                    end else if (scl_fall) begin
                        cnt_d = '0;
                        if (!ack_q) begin
                            state_d  = ST_TX;
                            txsh_d   = tx_data;
                            tx_req_d = 1'b1;
                            sda_oe_d = ~tx_data[7];
                        end else begin
                            state_d  = ST_WAIT_STOP;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_WAIT_STOP: sda_oe_d = 1'b0;
            endcase
        end
    end
endmodule

// File: doc/i2c_subordinate.md
I2C_SUBORDINATE -- requirements
Module: i2c_subordinate

Interface
- REQ-001: Parameter ADDR, default 7'h01, 7-bit bus address the block answers to.
- REQ-002: clk  input  1  system clock (100 MHz); all logic on its rising edge.
- REQ-003: rst  input  1  reset, synchronous, active-high.
- REQ-004: scl  input  1  raw I2C clock from the bus (asynchronous to clk).
- REQ-005: sda_in  input  1  raw I2C data read from the bus (asynchronous to clk).
- REQ-006: sda_oe  output  1  1 = pull SDA low; 0 = release SDA (pullup gives 1).
- REQ-007: rx_data  output  8  last data byte written by the master.
- REQ-008: rx_valid  output  1  one-clk pulse when rx_data updates.
- REQ-009: tx_data  input  8  byte returned to the master on a read; sampled when tx_req pulses.
- REQ-010: tx_req  output  1  one-clk pulse when tx_data is latched.
- REQ-011: addr_match  output  1  high from address ACK until the next START or STOP.
- REQ-012: busy  output  1  high between a detected START and the next STOP.
- REQ-013: state_out  output  3  current FSM state encoding, for debug.

Function
- REQ-014: scl and sda_in SHALL pass through 2-flop synchronizers; edges SHALL be detected by comparing the synchronized value with a 3rd registered copy (3-clk detection latency).
- REQ-015: START SHALL be detected as SDA falling while SCL high; STOP as SDA rising while SCL high; both SHALL override any state.
- REQ-016: FSM states and encoding: IDLE=0, ADDR=1, ADDR_ACK=2, RX=3, RX_ACK=4, TX=5, TX_ACK=6, WAIT_STOP=7.
- REQ-017: START from any state -> ADDR, bit counter cleared, sda_oe=0, busy=1, addr_match=0.
- REQ-018: STOP from any state -> IDLE, sda_oe=0, busy=0, addr_match=0.
- REQ-019: Bits SHALL be sampled MSB first on detected SCL rising edges; sda_oe SHALL change only on detected SCL falling edges, except on START, STOP or reset.
- REQ-020: ADDR: after 8 bits, {addr[6:0], rw} is held; on the next SCL fall: match -> ADDR_ACK with sda_oe=1, addr_match=1; mismatch -> WAIT_STOP with sda_oe=0.
- REQ-021: ADDR_ACK, on SCL fall: rw=0 -> RX, sda_oe=0; rw=1 -> TX, latch tx_data, pulse tx_req, sda_oe=~tx_data[7].
- REQ-022: RX: after the 8th bit, on SCL fall: rx_data <= shifted byte, rx_valid pulses, sda_oe=1, -> RX_ACK; every written byte SHALL be ACKed.
- REQ-023: RX_ACK, on SCL fall: sda_oe=0, -> RX (next byte).
- REQ-024: TX: on each SCL fall, sda_oe SHALL present ~(next bit); after the 8th bit's SCL fall, sda_oe=0 and state -> TX_ACK.
- REQ-025: TX_ACK: master bit sampled on SCL rise. ACK (0): next SCL fall latches tx_data, pulses tx_req, drives the MSB, -> TX. NACK (1): -> WAIT_STOP, sda_oe=0.
- REQ-026: WAIT_STOP: sda_oe=0; ignore SCL edges; leave only on START or STOP.
- REQ-027: sda_oe SHALL never be 1 in IDLE or WAIT_STOP.
- REQ-028: rx_valid and tx_req SHALL each be high for exactly one clk per byte.

Reset
- REQ-029: When rst=1 at a clk edge: state=IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, addr_match=0, busy=0, synchronizer flops=1. This holds when reset occurs mid-byte.
- REQ-030: After reset, the block SHALL ignore bus activity until the next START.

Verification
- REQ-031: Write. START, 0x02, 0x81, STOP at 400 kHz -> sda_oe=1 during both ACK slots, rx_data=0x81, one rx_valid pulse, busy 1->0 after STOP.
- REQ-032: Mismatch. START, 0x0A (addr 0x05) -> sda_oe stays 0 for the whole transfer, state=7 until STOP, addr_match=0.
- REQ-033: Read. START, 0x03, tx_data=0xA5, master NACK, STOP -> bus bits 1010_0101, one tx_req pulse, state 6->7->0.
- REQ-034: Multi-byte write. 0x02, 0x11, 0x22 -> two rx_valid pulses with rx_data 0x11 then 0x22, all ACKed.
- REQ-035: Repeated START. Write 0x02, 0x33, then START, 0x03 read with tx_data=0x5A, master ACK then NACK -> 0x5A sent twice, two tx_req pulses.
- REQ-036: Reset mid-read, with sda_oe=1 -> sda_oe=0 at the next clk edge, state=0, later START works normally.
